// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program counter and instruction-fetch stage feeding the picoMIPS decoder.
// Drives the address of a synchronous program ROM (1-cycle read latency),
// presents the fetched word and its opcode field, forms the next PC from the
// decoder's PC-control inputs, detects the halt opcode and counts retired
// instructions (saturating).
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   PCincr       advance PC by 1
//   PCabsbranch  PC <= Branchaddr
//   PCrelbranch  PC <= PC + signed Branchaddr
//   Branchaddr   absolute target or two's-complement offset
//   stall        hold PC and current instruction
//   imem_addr    ROM address (next PC, combinational)
//   imem_data    ROM read data
//   instr        current instruction
//   opcode       instr[Isize-1:Isize-6]
//   instr_valid  instr/opcode valid for the decoder
//   pc           address of current instruction
//   halted       fetch unit halted
//   retired      retired-instruction count
//
// state  | meaning
// S_FILL | one cycle after reset while ROM output catches up with pc
// S_RUN  | instruction valid, PC follows decoder controls
// S_HALT | halt opcode executed, everything frozen until reset
module pc_fetch_unit #(
  parameter int         Psize   = 6,
  parameter int         Isize   = 16,
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter int         Csize   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCincr,
  input  logic             PCabsbranch,
  input  logic             PCrelbranch,
  input  logic [Psize-1:0] Branchaddr,
  input  logic             stall,
  output logic [Psize-1:0] imem_addr,
  input  logic [Isize-1:0] imem_data,
  output logic [Isize-1:0] instr,
  output logic [5:0]       opcode,
  output logic             instr_valid,
  output logic [Psize-1:0] pc,
  output logic             halted,
  output logic [Csize-1:0] retired
);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_HALT} state_t;

  localparam logic [Psize-1:0] PC_ONE  = {{(Psize-1){1'b0}}, 1'b1};
  localparam logic [Csize-1:0] CNT_ONE = {{(Csize-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [Psize-1:0] r_pc;
  logic [Psize-1:0] w_pc_next;
  logic [Csize-1:0] r_retired;
  logic             w_is_halt_op;

  assign w_is_halt_op = (imem_data[Isize-1 -: 6] == HALT_OP);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      S_FILL: w_state_next = S_RUN;
      S_RUN: begin
        if (!stall) begin
          if (w_is_halt_op) begin
            w_state_next = S_HALT;
          end else if (PCabsbranch) begin
            w_pc_next = Branchaddr;
          end else if (PCrelbranch) begin
            // Same-width add is the sign-extended add modulo 2^Psize.
            w_pc_next = r_pc + Branchaddr;
          end else if (PCincr) begin
            w_pc_next = r_pc + PC_ONE;
          end
        end
      end
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FILL;
      r_pc      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (r_state == S_RUN && !stall && r_retired != {Csize{1'b1}}) begin
        r_retired <= r_retired + CNT_ONE;
      end
    end
  end

  // Forcing address 0 during reset makes the ROM hold word 0 when FILL starts.
  assign imem_addr   = reset ? '0 : w_pc_next;
  assign instr       = imem_data;
  assign opcode      = imem_data[Isize-1 -: 6];
  assign instr_valid = (r_state == S_RUN);
  assign halted      = (r_state == S_HALT);
  assign pc          = r_pc;
  assign retired     = r_retired;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, PCincr, PCabsbranch, PCrelbranch, stall;
  logic [5:0]  Branchaddr;

  logic [5:0]  imem_addr, imem_addr4, pc, pc4, opcode, opcode4;
  logic [15:0] instr, instr4, rom_q, rom4_q, retired;
  logic [3:0]  retired4;
  logic        instr_valid, instr_valid4, halted, halted4;

  logic [15:0] mem [0:63];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q  <= mem[imem_addr];
    rom4_q <= mem[imem_addr4];
  end

  pc_fetch_unit #(.Psize(6), .Isize(16), .HALT_OP(6'b111111), .Csize(16)) dut (
    .clk(clk), .reset(reset), .PCincr(PCincr), .PCabsbranch(PCabsbranch),
    .PCrelbranch(PCrelbranch), .Branchaddr(Branchaddr), .stall(stall),
    .imem_addr(imem_addr), .imem_data(rom_q), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .pc(pc), .halted(halted), .retired(retired)
  );

  pc_fetch_unit #(.Psize(6), .Isize(16), .HALT_OP(6'b111111), .Csize(4)) dut4 (
    .clk(clk), .reset(reset), .PCincr(PCincr), .PCabsbranch(PCabsbranch),
    .PCrelbranch(PCrelbranch), .Branchaddr(Branchaddr), .stall(stall),
    .imem_addr(imem_addr4), .imem_data(rom4_q), .instr(instr4), .opcode(opcode4),
    .instr_valid(instr_valid4), .pc(pc4), .halted(halted4), .retired(retired4)
  );

  typedef struct packed {
    logic [5:0]  pc;
    logic [15:0] instr;
    logic        valid;
    logic        halted;
    logic [15:0] ret;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   stepn = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge,
  // then pop and compare against both instances.
  task automatic step(input logic rst, input logic inc, input logic abs,
                      input logic rel, input logic st, input logic [5:0] ba,
                      input logic [5:0] epc, input logic [15:0] einstr,
                      input logic ev, input logic eh, input logic [15:0] eret);
    exp_t e;
    logic [3:0] eret4;
    reset = rst; PCincr = inc; PCabsbranch = abs; PCrelbranch = rel;
    stall = st; Branchaddr = ba;
    q.push_back('{pc: epc, instr: einstr, valid: ev, halted: eh, ret: eret});
    @(posedge clk);
    #1;
    stepn++;
    e = q.pop_front();
    eret4 = (e.ret > 16'd15) ? 4'd15 : e.ret[3:0];
    chk($sformatf("s%0d_pc", stepn),      {26'd0, pc},           {26'd0, e.pc});
    chk($sformatf("s%0d_instr", stepn),   {16'd0, instr},        {16'd0, e.instr});
    chk($sformatf("s%0d_opcode", stepn),  {26'd0, opcode},       {26'd0, e.instr[15:10]});
    chk($sformatf("s%0d_valid", stepn),   {31'd0, instr_valid},  {31'd0, e.valid});
    chk($sformatf("s%0d_halted", stepn),  {31'd0, halted},       {31'd0, e.halted});
    chk($sformatf("s%0d_retired", stepn), {16'd0, retired},      {16'd0, e.ret});
    chk($sformatf("s%0d_c4_pc", stepn),   {26'd0, pc4},          {26'd0, e.pc});
    chk($sformatf("s%0d_c4_instr", stepn),{10'd0, opcode4, instr4}, {10'd0, e.instr[15:10], e.instr});
    chk($sformatf("s%0d_c4_flags", stepn),{30'd0, instr_valid4, halted4}, {30'd0, e.valid, e.halted});
    chk($sformatf("s%0d_c4_retired", stepn), {28'd0, retired4},  {28'd0, eret4});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'(i);
    reset = 1'b1; PCincr = 1'b0; PCabsbranch = 1'b0; PCrelbranch = 1'b0;
    stall = 1'b0; Branchaddr = 6'd0;
    @(posedge clk);
    #1;

    // Reset, FILL, then sequential fetch
    step(1, 1, 0, 0, 0, 6'd0,  6'd0, 16'd0, 0, 0, 16'd0);
    step(0, 1, 0, 0, 0, 6'd0,  6'd0, 16'd0, 1, 0, 16'd0);
    step(0, 1, 0, 0, 0, 6'd0,  6'd1, 16'd1, 1, 0, 16'd1);
    step(0, 1, 0, 0, 0, 6'd0,  6'd2, 16'd2, 1, 0, 16'd2);
    step(0, 1, 0, 0, 0, 6'd0,  6'd3, 16'd3, 1, 0, 16'd3);
    step(0, 1, 0, 0, 0, 6'd0,  6'd4, 16'd4, 1, 0, 16'd4);
    step(0, 1, 0, 0, 0, 6'd0,  6'd5, 16'd5, 1, 0, 16'd5);
    // Branches: rel -3 from 5, abs 40 from 2, abs+rel both set
    step(0, 1, 0, 1, 0, 6'b111101, 6'd2, 16'd2, 1, 0, 16'd6);
    step(0, 1, 1, 0, 0, 6'd40, 6'd40, 16'd40, 1, 0, 16'd7);
    step(0, 0, 1, 0, 0, 6'd7,  6'd7,  16'd7,  1, 0, 16'd8);
    step(0, 1, 1, 1, 0, 6'd9,  6'd9,  16'd9,  1, 0, 16'd9);
    // Increment wrap at 63
    step(0, 0, 1, 0, 0, 6'd63, 6'd63, 16'd63, 1, 0, 16'd10);
    step(0, 1, 0, 0, 0, 6'd0,  6'd0,  16'd0,  1, 0, 16'd11);
    // Hold at 10 with no control, retired still counts
    step(0, 0, 1, 0, 0, 6'd10, 6'd10, 16'd10, 1, 0, 16'd12);
    step(0, 0, 0, 0, 0, 6'd33, 6'd10, 16'd10, 1, 0, 16'd13);
    step(0, 0, 0, 0, 0, 6'd0,  6'd10, 16'd10, 1, 0, 16'd14);
    // Stall at 12 for 3 cycles, stall beats a branch too
    step(0, 0, 1, 0, 0, 6'd12, 6'd12, 16'd12, 1, 0, 16'd15);
    step(0, 1, 0, 0, 1, 6'd0,  6'd12, 16'd12, 1, 0, 16'd15);
    step(0, 1, 1, 0, 1, 6'd50, 6'd12, 16'd12, 1, 0, 16'd15);
    step(0, 1, 0, 0, 1, 6'd0,  6'd12, 16'd12, 1, 0, 16'd15);
    step(0, 1, 0, 0, 0, 6'd0,  6'd13, 16'd13, 1, 0, 16'd16);
    // Reset during stall at pc=12
    step(0, 0, 1, 0, 0, 6'd12, 6'd12, 16'd12, 1, 0, 16'd17);
    step(0, 1, 0, 0, 1, 6'd0,  6'd12, 16'd12, 1, 0, 16'd17);
    step(1, 1, 0, 0, 1, 6'd0,  6'd0,  16'd0,  0, 0, 16'd0);
    step(0, 1, 0, 0, 0, 6'd0,  6'd0,  16'd0,  1, 0, 16'd0);
    // 20 RUN cycles: 16-bit counter keeps going, 4-bit one stops at 15
    for (int k = 1; k <= 20; k++)
      step(0, 1, 0, 0, 0, 6'd0, 6'(k), 16'(k), 1, 0, 16'(k));

    // Halt at mem[4], deferred by one stall cycle
    mem[4] = 16'hFC00;
    step(1, 1, 0, 0, 0, 6'd0, 6'd0, 16'd0, 0, 0, 16'd0);
    step(0, 1, 0, 0, 0, 6'd0, 6'd0, 16'd0, 1, 0, 16'd0);
    step(0, 1, 0, 0, 0, 6'd0, 6'd1, 16'd1, 1, 0, 16'd1);
    step(0, 1, 0, 0, 0, 6'd0, 6'd2, 16'd2, 1, 0, 16'd2);
    step(0, 1, 0, 0, 0, 6'd0, 6'd3, 16'd3, 1, 0, 16'd3);
    step(0, 1, 0, 0, 0, 6'd0, 6'd4, 16'hFC00, 1, 0, 16'd4);
    step(0, 1, 0, 0, 1, 6'd0, 6'd4, 16'hFC00, 1, 0, 16'd4);
    step(0, 1, 1, 0, 0, 6'd20, 6'd4, 16'hFC00, 0, 1, 16'd5);
    for (int k = 0; k < 10; k++)
      step(0, 1, k[0], ~k[0], k[1], 6'd33, 6'd4, 16'hFC00, 0, 1, 16'd5);
    step(1, 0, 0, 0, 0, 6'd0, 6'd0, 16'd0, 0, 0, 16'd0);
    step(0, 1, 0, 0, 0, 6'd0, 6'd0, 16'd0, 1, 0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter and instruction-fetch stage directly upstream of the picoMIPS instruction decoder.
- Drives the synchronous program ROM address and presents the fetched instruction, with its 6-bit opcode split out, to the decoder.
- Applies the decoder's PC-control signals to form the next PC: increment, absolute branch, relative branch, hold.
- Handles stall, halt-opcode detection and a retired-instruction counter.

Parameters:
Psize, 6, PC / program address width in bits
Isize, 16, instruction width in bits; opcode is instr[Isize-1:Isize-6]
HALT_OP, 6'b111111, opcode value that halts the fetch unit
Csize, 16, retired-instruction counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
PCincr  input  1  from decoder: advance PC by 1
PCabsbranch  input  1  from decoder: PC <= Branchaddr
PCrelbranch  input  1  from decoder: PC <= PC + signed Branchaddr
Branchaddr  input  Psize  branch target (abs) or two's-complement offset (rel)
stall  input  1  hold PC and current instruction this cycle
imem_addr  output  Psize  combinational address to synchronous ROM (= pc_next)
imem_data  input  Isize  ROM read data, registered in ROM, 1-cycle latency
instr  output  Isize  current instruction (= imem_data)
opcode  output  6  instr[Isize-1:Isize-6]
instr_valid  output  1  instr/opcode are valid for the decoder
pc  output  Psize  address of current instruction
halted  output  1  fetch unit in HALT state
retired  output  Csize  count of executed instructions

Behaviour:
- FSM states: FILL, RUN, HALT.
- Reset (reset=1 at a clock edge): pc<=0, state<=FILL, retired<=0. While reset=1, imem_addr=0, so the ROM latches word 0 on the reset edge. Output values after reset: instr_valid=0, halted=0, pc=0, retired=0.
- FILL: lasts exactly 1 cycle. imem_addr=pc (hold), instr_valid=0, all control inputs ignored. Next state is RUN.
- ROM alignment: imem_addr is always pc_next, so imem_data always holds mem[pc] in the following cycle (zero-bubble fetch).
- RUN: instr_valid=1.
  - pc_next priority: stall (hold) > PCabsbranch (Branchaddr) > PCrelbranch (pc + Branchaddr, sign-extended, mod 2^Psize) > PCincr (pc+1 mod 2^Psize) > hold.
  - Simultaneous abs+rel: abs wins.
  - Increment wrap: pc = 2^Psize-1 increments to 0.
- Halt: in RUN with opcode==HALT_OP and stall=0, state<=HALT and pc holds, regardless of the PC-control inputs. With stall=1 the halt is deferred until stall=0.
- HALT: halted=1, instr_valid=0, pc and imem_addr hold. All inputs except reset are ignored. Exit only via reset.
- retired: increments by 1 at each edge where state==RUN && stall==0, including the HALT_OP instruction itself. Saturates at 2^Csize-1 (no wrap).
- Reset mid-operation (any state, including during stall or HALT) returns to the reset values above. The next instruction seen is mem[0].
- All outputs except imem_addr, instr and opcode come from registers or pure decodes of state.

Test Plan:
- Reset then sequential run:
  - ROM mem[i]=i, opcodes≠HALT_OP, PCincr=1.
  - instr_valid=0 in the cycle after reset; then instr=0,1,2,3 on consecutive cycles with pc=0,1,2,3.
  - retired=4 after 4 RUN cycles.
- Branches:
  - At pc=5, PCrelbranch=1 with Branchaddr=6'b111101 (-3): next pc=2.
  - At pc=2, PCabsbranch=1 with Branchaddr=40: next pc=40, instr=mem[40].
  - At pc=7, PCabsbranch=1 and PCrelbranch=1, Branchaddr=9: next pc=9.
- Wrap and hold:
  - At pc=63, PCincr=1: next pc=0.
  - At pc=10 with PCincr=0 and no branch: pc stays 10, retired still increments.
- Stall:
  - At pc=12, stall=1 for 3 cycles with PCincr=1: pc=12 and instr=mem[12] held, retired unchanged.
  - On the first cycle after stall=0: pc=13.
- Halt:
  - mem[4]=HALT_OP, PCincr=1: after pc=4, halted=1 and instr_valid=0, pc=4 held for ≥10 cycles, retired=5.
  - Assert reset: pc=0, halted=0.
- Saturation:
  - Csize=4, 20 RUN cycles: retired stops at 15.
  - Reset during stall at pc=12: pc=0, FILL entered.
